// File: rtl/level_sequencer.sv
// Bopit level progression: scores hits, advances levels and steps difficulty incrementally.
// All outputs registered (one cycle after the causing input); no backpressure, pulses are sampled once.
module level_sequencer #(
  parameter int NUM_LEVELS  = 8,
  parameter int LVL_W       = 4,
  parameter int FREQ_W      = 29,
  parameter int BASE_FREQ   = 200000000,
  parameter int FREQ_STEP   = 50000000,
  parameter int MIN_FREQ    = 100000000,
  parameter int FREQ_EVERY  = 4,
  parameter int BASE_ELEM   = 5,
  parameter int ELEM_STEP   = 4,
  parameter int ELEM_EVERY  = 2,
  parameter int MAX_ELEM    = 13,
  parameter int BASE_MOVE   = 1,
  parameter int MOVE_EVERY  = 2,
  parameter int MAX_MOVE    = 4,
  parameter int PTS_PER_LVL = 8,
  parameter int MAX_MISSES  = 3,
  parameter int PAUSE_CYC   = 100000000,
  localparam int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hit,
  input  logic              miss,
  output logic [LVL_W-1:0]  level,
  output logic [31:0]       score,
  output logic [MISS_W-1:0] misses,
  output logic [FREQ_W-1:0] play_freq,
  output logic [3:0]        play_elements,
  output logic [2:0]        move_elements,
  output logic [31:0]       max_points,
  output logic              playing,
  output logic              level_up,
  output logic              win,
  output logic              game_over
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_LVLUP, S_WIN, S_OVER} state_t;

  localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_LAST   = LVL_W'(NUM_LEVELS);
  localparam logic [FREQ_W-1:0] F_BASE     = FREQ_W'(BASE_FREQ);
  localparam logic [FREQ_W-1:0] F_STEP     = FREQ_W'(FREQ_STEP);
  localparam logic [FREQ_W-1:0] F_MIN      = FREQ_W'(MIN_FREQ);
  localparam logic [FREQ_W:0]   F_LIM      = (FREQ_W+1)'(MIN_FREQ + FREQ_STEP);
  localparam logic [3:0]        E_BASE     = 4'(BASE_ELEM);
  localparam logic [3:0]        E_MAX      = 4'(MAX_ELEM);
  localparam logic [2:0]        M_BASE     = 3'(BASE_MOVE);
  localparam logic [2:0]        M_MAX      = 3'(MAX_MOVE);
  localparam logic [31:0]       P_STEP     = 32'(PTS_PER_LVL);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MAX_MISSES);
  localparam logic [31:0]       PAUSE_LOAD = 32'(PAUSE_CYC - 1);
  localparam logic [7:0]        F_LAST     = 8'(FREQ_EVERY - 1);
  localparam logic [7:0]        E_LAST     = 8'(ELEM_EVERY - 1);
  localparam logic [7:0]        M_LAST     = 8'(MOVE_EVERY - 1);
  // Move steps when the level itself is a multiple of MOVE_EVERY (L2, L4, ...),
  // while freq/elements step on (level-1) multiples, hence the different phase.
  localparam logic [7:0]        M_INIT     = 8'(1 % MOVE_EVERY);

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [31:0]         score_q, score_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [3:0]          elem_q, elem_d;
  logic [2:0]          move_q, move_d;
  logic [31:0]         pts_q, pts_d;
  logic [31:0]         pause_q, pause_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic [7:0]          ecnt_q, ecnt_d;
  logic [7:0]          mcnt_q, mcnt_d;
  logic                level_up_q, level_up_d;
  logic                playing_q, win_q, over_q;
  logic [7:0]          elem_sum, move_sum;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    misses_d   = misses_q;
    freq_d     = freq_q;
    elem_d     = elem_q;
    move_d     = move_q;
    pts_d      = pts_q;
    pause_d    = pause_q;
    fcnt_d     = fcnt_q;
    ecnt_d     = ecnt_q;
    mcnt_d     = mcnt_q;
    level_up_d = 1'b0;
    elem_sum   = {4'b0, elem_q} + 8'(ELEM_STEP);
    move_sum   = {5'b0, move_q} + 8'd1;

    case (state_q)
      S_IDLE, S_WIN, S_OVER: begin
        if (start) begin
          state_d  = S_PLAY;
          level_d  = LVL_ONE;
          score_d  = '0;
          misses_d = '0;
          freq_d   = F_BASE;
          elem_d   = E_BASE;
          move_d   = M_BASE;
          pts_d    = P_STEP;
          fcnt_d   = '0;
          ecnt_d   = '0;
          mcnt_d   = M_INIT;
        end
      end
      S_PLAY: begin
        // A simultaneous miss takes priority and discards the hit.
        if (miss) begin
          misses_d = misses_q + MISS_W'(1);
          if (misses_d == MISS_MAX) state_d = S_OVER;
        end else if (hit) begin
          if (score_q + 32'd1 == pts_q) begin
            score_d = '0;
            if (level_q == LVL_LAST) begin
              state_d = S_WIN;
            end else begin
              state_d    = S_LVLUP;
              level_up_d = 1'b1;
              pause_d    = PAUSE_LOAD;
            end
          end else begin
            score_d = score_q + 32'd1;
          end
        end
      end
      S_LVLUP: begin
        if (pause_q == '0) begin
          state_d  = S_PLAY;
          level_d  = level_q + LVL_ONE;
          misses_d = '0;
          pts_d    = pts_q + P_STEP;
          if (fcnt_q == F_LAST) begin
            fcnt_d = '0;
            // Compare before subtracting so the floor clamp can never wrap.
            freq_d = ({1'b0, freq_q} < F_LIM) ? F_MIN : freq_q - F_STEP;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
          if (ecnt_q == E_LAST) begin
            ecnt_d = '0;
            elem_d = (elem_sum > 8'(MAX_ELEM)) ? E_MAX : elem_sum[3:0];
          end else begin
            ecnt_d = ecnt_q + 8'd1;
          end
          if (mcnt_q == M_LAST) begin
            mcnt_d = '0;
            move_d = (move_sum > 8'(MAX_MOVE)) ? M_MAX : move_sum[2:0];
          end else begin
            mcnt_d = mcnt_q + 8'd1;
          end
        end else begin
          pause_d = pause_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_q    <= LVL_ONE;
      score_q    <= '0;
      misses_q   <= '0;
      freq_q     <= F_BASE;
      elem_q     <= E_BASE;
      move_q     <= M_BASE;
      pts_q      <= P_STEP;
      pause_q    <= '0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
      mcnt_q     <= M_INIT;
      level_up_q <= 1'b0;
      playing_q  <= 1'b0;
      win_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      freq_q     <= freq_d;
      elem_q     <= elem_d;
      move_q     <= move_d;
      pts_q      <= pts_d;
      pause_q    <= pause_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
      mcnt_q     <= mcnt_d;
      level_up_q <= level_up_d;
      playing_q  <= (state_d == S_PLAY);
      win_q      <= (state_d == S_WIN);
      over_q     <= (state_d == S_OVER);
    end
  end

  assign level         = level_q;
  assign score         = score_q;
  assign misses        = misses_q;
  assign play_freq     = freq_q;
  assign play_elements = elem_q;
  assign move_elements = move_q;
  assign max_points    = pts_q;
  assign playing       = playing_q;
  assign level_up      = level_up_q;
  assign win           = win_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: default build plus a saturating-frequency build.
module tb_level_sequencer;

  localparam int PAUSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [3:0]  level;
  logic [31:0] score, max_points;
  logic [1:0]  misses;
  logic [28:0] play_freq;
  logic [3:0]  play_elements;
  logic [2:0]  move_elements;
  logic        playing, level_up, win, game_over;

  logic s_start = 1'b0, s_hit = 1'b0, s_miss = 1'b0;
  logic [3:0]  s_level;
  logic [31:0] s_score, s_max_points;
  logic [1:0]  s_misses;
  logic [28:0] s_play_freq;
  logic [3:0]  s_play_elements;
  logic [2:0]  s_move_elements;
  logic        s_playing, s_level_up, s_win, s_game_over;

  int checks = 0;
  int errors = 0;

  level_sequencer #(.PAUSE_CYC(PAUSE)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
    .level(level), .score(score), .misses(misses), .play_freq(play_freq),
    .play_elements(play_elements), .move_elements(move_elements),
    .max_points(max_points), .playing(playing), .level_up(level_up),
    .win(win), .game_over(game_over)
  );

  level_sequencer #(.PAUSE_CYC(PAUSE), .FREQ_STEP(80000000), .NUM_LEVELS(12)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .hit(s_hit), .miss(s_miss),
    .level(s_level), .score(s_score), .misses(s_misses), .play_freq(s_play_freq),
    .play_elements(s_play_elements), .move_elements(s_move_elements),
    .max_points(s_max_points), .playing(s_playing), .level_up(s_level_up),
    .win(s_win), .game_over(s_game_over)
  );

  // One clock with the given inputs; outputs are then sampled 1ns after the edge.
  task automatic step(input logic h, input logic m, input logic s);
    hit = h; miss = m; start = s;
    @(posedge clk); #1;
    hit = 1'b0; miss = 1'b0; start = 1'b0;
  endtask

  task automatic clear_level(input int pts);
    repeat (pts) step(1'b1, 1'b0, 1'b0);
    repeat (PAUSE) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL reset_level got=%0d exp=1", level); end
    checks++; if (play_freq !== 29'd200000000) begin errors++; $display("FAIL reset_freq got=%0d exp=200000000", play_freq); end
    checks++; if (play_elements !== 4'd5) begin errors++; $display("FAIL reset_elem got=%0d exp=5", play_elements); end
    checks++; if (move_elements !== 3'd1) begin errors++; $display("FAIL reset_move got=%0d exp=1", move_elements); end
    checks++; if (max_points !== 32'd8) begin errors++; $display("FAIL reset_pts got=%0d exp=8", max_points); end
    checks++; if ({playing, win, game_over, level_up} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {playing, win, game_over, level_up}); end
    checks++; if (score !== 32'd0 || misses !== 2'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", score, misses); end
  endtask

  task automatic test_level_up;
    step(1'b0, 1'b0, 1'b1);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL start_playing got=%b exp=1", playing); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (misses !== 2'd1 || score !== 32'd0) begin errors++; $display("FAIL l1_miss got=%0d/%0d exp=1/0", misses, score); end
    repeat (7) step(1'b1, 1'b0, 1'b0);
    checks++; if (score !== 32'd7 || level_up !== 1'b0) begin errors++; $display("FAIL seven_hits got=%0d/%b exp=7/0", score, level_up); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (level_up !== 1'b1 || score !== 32'd0 || playing !== 1'b0) begin errors++; $display("FAIL eighth_hit got=%b/%0d/%b exp=1/0/0", level_up, score, playing); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (level_up !== 1'b0 || score !== 32'd0) begin errors++; $display("FAIL lvlup_pulse got=%b/%0d exp=0/0", level_up, score); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (level !== 4'd1 || score !== 32'd0 || misses !== 2'd1) begin errors++; $display("FAIL pause_hold got=%0d/%0d/%0d exp=1/0/1", level, score, misses); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (level !== 4'd2 || max_points !== 32'd16 || move_elements !== 3'd2) begin errors++; $display("FAIL level2 got=%0d/%0d/%0d exp=2/16/2", level, max_points, move_elements); end
    checks++; if (play_elements !== 4'd5 || play_freq !== 29'd200000000) begin errors++; $display("FAIL level2_diff got=%0d/%0d exp=5/200000000", play_elements, play_freq); end
    checks++; if (misses !== 2'd0 || playing !== 1'b1) begin errors++; $display("FAIL level2_state got=%0d/%b exp=0/1", misses, playing); end
  endtask

  task automatic test_hit_miss;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (score !== 32'd3 || misses !== 2'd1) begin errors++; $display("FAIL hit_and_miss got=%0d/%0d exp=3/1", score, misses); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (misses !== 2'd2 || playing !== 1'b1) begin errors++; $display("FAIL second_miss got=%0d/%b exp=2/1", misses, playing); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (game_over !== 1'b1 || playing !== 1'b0 || misses !== 2'd3) begin errors++; $display("FAIL game_over got=%b/%b/%0d exp=1/0/3", game_over, playing, misses); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (score !== 32'd3 || game_over !== 1'b1) begin errors++; $display("FAIL over_hit got=%0d/%b exp=3/1", score, game_over); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (level !== 4'd1 || score !== 32'd0 || misses !== 2'd0 || max_points !== 32'd8) begin errors++; $display("FAIL restart got=%0d/%0d/%0d/%0d exp=1/0/0/8", level, score, misses, max_points); end
    checks++; if (game_over !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL restart_flags got=%b/%b exp=0/1", game_over, playing); end
  endtask

  task automatic test_progress;
    clear_level(8);
    clear_level(16);
    checks++; if (level !== 4'd3 || play_elements !== 4'd9 || move_elements !== 3'd2) begin errors++; $display("FAIL level3 got=%0d/%0d/%0d exp=3/9/2", level, play_elements, move_elements); end
    clear_level(24);
    checks++; if (move_elements !== 3'd3 || play_freq !== 29'd200000000) begin errors++; $display("FAIL level4 got=%0d/%0d exp=3/200000000", move_elements, play_freq); end
    clear_level(32);
    checks++; if (play_freq !== 29'd150000000 || play_elements !== 4'd13) begin errors++; $display("FAIL level5 got=%0d/%0d exp=150000000/13", play_freq, play_elements); end
    checks++; if (move_elements !== 3'd3 || max_points !== 32'd40) begin errors++; $display("FAIL level5_b got=%0d/%0d exp=3/40", move_elements, max_points); end
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++; if (score !== 32'd2 || level !== 4'd5 || playing !== 1'b1) begin errors++; $display("FAIL start_in_play got=%0d/%0d/%b exp=2/5/1", score, level, playing); end
    clear_level(38);
    clear_level(48);
    checks++; if (play_elements !== 4'd13 || move_elements !== 3'd4) begin errors++; $display("FAIL level7 got=%0d/%0d exp=13/4", play_elements, move_elements); end
    clear_level(56);
    checks++; if (level !== 4'd8 || max_points !== 32'd64 || move_elements !== 3'd4) begin errors++; $display("FAIL level8 got=%0d/%0d/%0d exp=8/64/4", level, max_points, move_elements); end
    repeat (63) step(1'b1, 1'b0, 1'b0);
    checks++; if (score !== 32'd63 || win !== 1'b0) begin errors++; $display("FAIL l8_63 got=%0d/%b exp=63/0", score, win); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (win !== 1'b1 || level !== 4'd8 || playing !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL win got=%b/%0d/%b/%b exp=1/8/0/0", win, level, playing, level_up); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (score !== 32'd0 || win !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL win_hold got=%0d/%b/%0d exp=0/1/8", score, win, level); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (win !== 1'b0 || level !== 4'd1 || play_freq !== 29'd200000000) begin errors++; $display("FAIL win_restart got=%b/%0d/%0d exp=0/1/200000000", win, level, play_freq); end
  endtask

  task automatic test_saturate;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int lv = 1; lv < 12; lv++) begin
      s_hit = 1'b1;
      repeat (8 * lv) @(posedge clk);
      #1 s_hit = 1'b0;
      repeat (PAUSE) @(posedge clk);
      #1;
      if (lv == 4) begin
        checks++; if (s_play_freq !== 29'd120000000) begin errors++; $display("FAIL sat_l5 got=%0d exp=120000000", s_play_freq); end
      end
      if (lv == 8) begin
        checks++; if (s_play_freq !== 29'd100000000) begin errors++; $display("FAIL sat_l9 got=%0d exp=100000000", s_play_freq); end
      end
    end
    checks++; if (s_level !== 4'd12 || s_play_freq !== 29'd100000000) begin errors++; $display("FAIL sat_l12 got=%0d/%0d exp=12/100000000", s_level, s_play_freq); end
    checks++; if (s_play_elements !== 4'd13 || s_move_elements !== 3'd4 || s_max_points !== 32'd96) begin errors++; $display("FAIL sat_l12_diff got=%0d/%0d/%0d exp=13/4/96", s_play_elements, s_move_elements, s_max_points); end
  endtask

  initial begin
    #2;
    test_reset;
    test_level_up;
    test_hit_miss;
    test_progress;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
